// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered 8-bit ALU slice:
//   - 4-bit opcodes (upper two bits select the function unit,
//     lower two bits select the operation inside that unit)
//   - unit-select encodings for ALU_FUN[3:2]
//   - compare result codes
// -----------------------------------------------------------------------------
package alu_pkg;

  // Arithmetic unit
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_MUL    = 4'b0010;
  localparam logic [3:0] ALU_DIV    = 4'b0011;
  // Logic unit
  localparam logic [3:0] ALU_AND    = 4'b0100;
  localparam logic [3:0] ALU_OR     = 4'b0101;
  localparam logic [3:0] ALU_NAND   = 4'b0110;
  localparam logic [3:0] ALU_NOR    = 4'b0111;
  // Compare unit
  localparam logic [3:0] ALU_CMP_NOP = 4'b1000;
  localparam logic [3:0] ALU_CMP_EQ  = 4'b1001;
  localparam logic [3:0] ALU_CMP_GT  = 4'b1010;
  localparam logic [3:0] ALU_CMP_LT  = 4'b1011;
  // Shift unit
  localparam logic [3:0] ALU_SHR_A  = 4'b1100;
  localparam logic [3:0] ALU_SHL_A  = 4'b1101;
  localparam logic [3:0] ALU_SHR_B  = 4'b1110;
  localparam logic [3:0] ALU_SHL_B  = 4'b1111;

  // Unit select carried on ALU_FUN[3:2]
  typedef enum logic [1:0] {
    SEL_ARITH = 2'b00,
    SEL_LOGIC = 2'b01,
    SEL_CMP   = 2'b10,
    SEL_SHIFT = 2'b11
  } unit_sel_e;

  // Compare result codes
  localparam logic [3:0] CMP_NONE = 4'd0;
  localparam logic [3:0] CMP_EQ   = 4'd1;
  localparam logic [3:0] CMP_GT   = 4'd2;
  localparam logic [3:0] CMP_LT   = 4'd3;

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational one-hot unit enable from the opcode's unit-select field.
// Ports:
//   sel          in  2  ALU_FUN[3:2]
//   Arith_Enable out 1  sel == 00
//   Logic_Enable out 1  sel == 01
//   CMP_Enable   out 1  sel == 10
//   Shift_Enable out 1  sel == 11
// -----------------------------------------------------------------------------
module alu_decoder
  import alu_pkg::*;
(
  input  logic [1:0] sel,
  output logic       Arith_Enable,
  output logic       Logic_Enable,
  output logic       CMP_Enable,
  output logic       Shift_Enable
);

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned; that is what keeps combinational blocks latch-free.
  always_comb begin
    Arith_Enable = 1'b0;
    Logic_Enable = 1'b0;
    CMP_Enable   = 1'b0;
    Shift_Enable = 1'b0;
    case (unit_sel_e'(sel))
      SEL_ARITH: Arith_Enable = 1'b1;
      SEL_LOGIC: Logic_Enable = 1'b1;
      SEL_CMP:   CMP_Enable   = 1'b1;
      SEL_SHIFT: Shift_Enable = 1'b1;
    endcase
  end

endmodule

// File: rtl/arith_unit.sv
// -----------------------------------------------------------------------------
// arith_unit
// Registered add / subtract / multiply / divide.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   enable          unit selected this cycle
//   fun   in 2      ALU_FUN[1:0]
//   A, B  in IN_WIDTH  unsigned operands
//   Arith_OUT  out OUT_WIDTH  result (zero when not enabled)
//   Carry_OUT  out 1          add carry / subtract borrow
//   Arith_Flag out 1          result valid
// -----------------------------------------------------------------------------
module arith_unit
  import alu_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enable,
  input  logic [1:0]           fun,
  input  logic [IN_WIDTH-1:0]  A,
  input  logic [IN_WIDTH-1:0]  B,
  output logic [OUT_WIDTH-1:0] Arith_OUT,
  output logic                 Carry_OUT,
  output logic                 Arith_Flag
);

  logic [OUT_WIDTH-1:0] a_ext;
  logic [OUT_WIDTH-1:0] b_ext;
  logic [OUT_WIDTH-1:0] sum;
  logic [OUT_WIDTH-1:0] result;
  logic                 carry;

  assign a_ext = OUT_WIDTH'(A);
  assign b_ext = OUT_WIDTH'(B);
  assign sum   = a_ext + b_ext;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (fun)
      ALU_ADD[1:0]: begin
        result = sum;
        carry  = sum[IN_WIDTH];
      end
      ALU_SUB[1:0]: begin
        // Wraps modulo 2^OUT_WIDTH; the borrow is reported separately.
        result = a_ext - b_ext;
        carry  = (A < B);
      end
      ALU_MUL[1:0]: result = a_ext * b_ext;
      // Divide by zero yields zero rather than an undefined quotient.
      ALU_DIV[1:0]: result = (B == '0) ? '0 : (a_ext / b_ext);
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Arith_OUT  <= '0;
      Carry_OUT  <= 1'b0;
      Arith_Flag <= 1'b0;
    end else if (enable) begin
      Arith_OUT  <= result;
      Carry_OUT  <= carry;
      Arith_Flag <= 1'b1;
    end else begin
      Arith_OUT  <= '0;
      Carry_OUT  <= 1'b0;
      Arith_Flag <= 1'b0;
    end
  end

endmodule

// File: rtl/cmp_unit.sv
// -----------------------------------------------------------------------------
// cmp_unit
// Registered comparator producing a small code rather than a bit vector.
// Ports:
//   CLK, RST, enable, fun[1:0], A, B   as for arith_unit
//   CMP_OUT  out 4  0 = no match / NOP, 1 = equal, 2 = greater, 3 = less
//   CMP_Flag out 1  result valid
// -----------------------------------------------------------------------------
module cmp_unit
  import alu_pkg::*;
#(
  parameter int IN_WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                enable,
  input  logic [1:0]          fun,
  input  logic [IN_WIDTH-1:0] A,
  input  logic [IN_WIDTH-1:0] B,
  output logic [3:0]          CMP_OUT,
  output logic                CMP_Flag
);

  logic [3:0] code;

  // Each opcode tests one relation only; a false relation reports CMP_NONE.
  always_comb begin
    code = CMP_NONE;
    case (fun)
      ALU_CMP_NOP[1:0]: code = CMP_NONE;
      ALU_CMP_EQ[1:0]:  code = (A == B) ? CMP_EQ : CMP_NONE;
      ALU_CMP_GT[1:0]:  code = (A >  B) ? CMP_GT : CMP_NONE;
      ALU_CMP_LT[1:0]:  code = (A <  B) ? CMP_LT : CMP_NONE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      CMP_OUT  <= CMP_NONE;
      CMP_Flag <= 1'b0;
    end else if (enable) begin
      CMP_OUT  <= code;
      CMP_Flag <= 1'b1;
    end else begin
      CMP_OUT  <= CMP_NONE;
      CMP_Flag <= 1'b0;
    end
  end

endmodule

// File: rtl/logic_unit.sv
// -----------------------------------------------------------------------------
// logic_unit
// Registered bitwise AND / OR / NAND / NOR on IN_WIDTH bits, zero-extended.
// Ports:
//   CLK, RST, enable, fun[1:0], A, B   as for arith_unit
//   Logic_OUT  out OUT_WIDTH  result (zero when not enabled)
//   Logic_Flag out 1          result valid
// -----------------------------------------------------------------------------
module logic_unit
  import alu_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enable,
  input  logic [1:0]           fun,
  input  logic [IN_WIDTH-1:0]  A,
  input  logic [IN_WIDTH-1:0]  B,
  output logic [OUT_WIDTH-1:0] Logic_OUT,
  output logic                 Logic_Flag
);

  // Inversions happen at operand width so NAND/NOR do not set upper bits.
  logic [IN_WIDTH-1:0] result;

  always_comb begin
    result = '0;
    case (fun)
      ALU_AND[1:0]:  result = A & B;
      ALU_OR[1:0]:   result = A | B;
      ALU_NAND[1:0]: result = ~(A & B);
      ALU_NOR[1:0]:  result = ~(A | B);
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Logic_OUT  <= '0;
      Logic_Flag <= 1'b0;
    end else if (enable) begin
      Logic_OUT  <= OUT_WIDTH'(result);
      Logic_Flag <= 1'b1;
    end else begin
      Logic_OUT  <= '0;
      Logic_Flag <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
// Registered single-bit logical shifts of A or B, zero fill.
// Ports:
//   CLK, RST, enable, fun[1:0], A, B   as for arith_unit
//   SHIFT_OUT  out OUT_WIDTH  result (zero when not enabled)
//   SHIFT_Flag out 1          result valid
// -----------------------------------------------------------------------------
module shift_unit
  import alu_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enable,
  input  logic [1:0]           fun,
  input  logic [IN_WIDTH-1:0]  A,
  input  logic [IN_WIDTH-1:0]  B,
  output logic [OUT_WIDTH-1:0] SHIFT_OUT,
  output logic                 SHIFT_Flag
);

  logic [OUT_WIDTH-1:0] result;

  // Left shifts keep the bit shifted out of the operand: the result is
  // IN_WIDTH+1 significant bits wide.
  always_comb begin
    result = '0;
    case (fun)
      ALU_SHR_A[1:0]: result = OUT_WIDTH'(A >> 1);
      ALU_SHL_A[1:0]: result = OUT_WIDTH'({A, 1'b0});
      ALU_SHR_B[1:0]: result = OUT_WIDTH'(B >> 1);
      ALU_SHL_B[1:0]: result = OUT_WIDTH'({B, 1'b0});
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SHIFT_OUT  <= '0;
      SHIFT_Flag <= 1'b0;
    end else if (enable) begin
      SHIFT_OUT  <= result;
      SHIFT_Flag <= 1'b1;
    end else begin
      SHIFT_OUT  <= '0;
      SHIFT_Flag <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_top.sv
// -----------------------------------------------------------------------------
// alu_top
// Registered ALU: a combinational decoder enables one of four function units,
// each of which owns its registered result and valid flag (1-cycle latency).
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   A, B    in 8      unsigned operands
//   ALU_FUN in 4      opcode ([3:2] unit select, [1:0] operation)
//   *_Enable out 1    combinational one-hot unit enables
//   Arith_OUT/Carry_OUT/Arith_Flag   arithmetic result, carry/borrow, valid
//   Logic_OUT/Logic_Flag             logic result, valid
//   CMP_OUT/CMP_Flag                 compare code, valid
//   SHIFT_OUT/SHIFT_Flag             shift result, valid
// -----------------------------------------------------------------------------
module alu_top
  import alu_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [IN_WIDTH-1:0]  A,
  input  logic [IN_WIDTH-1:0]  B,
  input  logic [3:0]           ALU_FUN,
  output logic                 Arith_Enable,
  output logic                 Logic_Enable,
  output logic                 CMP_Enable,
  output logic                 Shift_Enable,
  output logic [OUT_WIDTH-1:0] Arith_OUT,
  output logic                 Carry_OUT,
  output logic                 Arith_Flag,
  output logic [OUT_WIDTH-1:0] Logic_OUT,
  output logic                 Logic_Flag,
  output logic [3:0]           CMP_OUT,
  output logic                 CMP_Flag,
  output logic [OUT_WIDTH-1:0] SHIFT_OUT,
  output logic                 SHIFT_Flag
);

  alu_decoder u_decoder (
    .sel          (ALU_FUN[3:2]),
    .Arith_Enable (Arith_Enable),
    .Logic_Enable (Logic_Enable),
    .CMP_Enable   (CMP_Enable),
    .Shift_Enable (Shift_Enable)
  );

  arith_unit #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_arith (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (Arith_Enable),
    .fun        (ALU_FUN[1:0]),
    .A          (A),
    .B          (B),
    .Arith_OUT  (Arith_OUT),
    .Carry_OUT  (Carry_OUT),
    .Arith_Flag (Arith_Flag)
  );

  logic_unit #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_logic (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (Logic_Enable),
    .fun        (ALU_FUN[1:0]),
    .A          (A),
    .B          (B),
    .Logic_OUT  (Logic_OUT),
    .Logic_Flag (Logic_Flag)
  );

  cmp_unit #(.IN_WIDTH(IN_WIDTH)) u_cmp (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (CMP_Enable),
    .fun      (ALU_FUN[1:0]),
    .A        (A),
    .B        (B),
    .CMP_OUT  (CMP_OUT),
    .CMP_Flag (CMP_Flag)
  );

  shift_unit #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_shift (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (Shift_Enable),
    .fun        (ALU_FUN[1:0]),
    .A          (A),
    .B          (B),
    .SHIFT_OUT  (SHIFT_OUT),
    .SHIFT_Flag (SHIFT_Flag)
  );

endmodule

// File: tb/tb_alu_top.sv
// -----------------------------------------------------------------------------
// tb_alu_top
// Directed, table-driven bench for alu_top with hand-computed expectations,
// plus hand-written reset and mid-sweep reset sequences.
// -----------------------------------------------------------------------------
module tb_alu_top;

  logic        CLK;
  logic        RST;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  ALU_FUN;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
  logic [15:0] Arith_OUT, Logic_OUT, SHIFT_OUT;
  logic        Carry_OUT, Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
  logic [3:0]  CMP_OUT;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_top dut (
    .CLK          (CLK),
    .RST          (RST),
    .A            (A),
    .B            (B),
    .ALU_FUN      (ALU_FUN),
    .Arith_Enable (Arith_Enable),
    .Logic_Enable (Logic_Enable),
    .CMP_Enable   (CMP_Enable),
    .Shift_Enable (Shift_Enable),
    .Arith_OUT    (Arith_OUT),
    .Carry_OUT    (Carry_OUT),
    .Arith_Flag   (Arith_Flag),
    .Logic_OUT    (Logic_OUT),
    .Logic_Flag   (Logic_Flag),
    .CMP_OUT      (CMP_OUT),
    .CMP_Flag     (CMP_Flag),
    .SHIFT_OUT    (SHIFT_OUT),
    .SHIFT_Flag   (SHIFT_Flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One stimulus record: operands, opcode, and the hand-computed result of
  // the unit that opcode selects (unit index 0..3 = arith/logic/cmp/shift).
  typedef struct {
    logic [3:0]  fun;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] val;
    logic        carry;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Checks every registered output given the unit expected to be active
  // (-1 = none) and that unit's expected value/carry.
  task automatic check_regs(input string tag, input int unit,
                            input logic [15:0] val, input logic carry);
    check({tag, " arith_out"}, 32'(Arith_OUT), (unit == 0) ? 32'(val) : 32'd0);
    check({tag, " carry"},     32'(Carry_OUT), (unit == 0) ? 32'(carry) : 32'd0);
    check({tag, " logic_out"}, 32'(Logic_OUT), (unit == 1) ? 32'(val) : 32'd0);
    check({tag, " cmp_out"},   32'(CMP_OUT),   (unit == 2) ? 32'(val) : 32'd0);
    check({tag, " shift_out"}, 32'(SHIFT_OUT), (unit == 3) ? 32'(val) : 32'd0);
    check({tag, " flags"},
          32'({Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag}),
          (unit < 0) ? 32'd0 : 32'(4'b1000 >> unit));
  endtask

  initial begin
    // Operands 0x55 / 0x33 sweep
    vecs.push_back(vec_t'{4'b0000, 8'h55, 8'h33, 16'h0088, 1'b0});
    vecs.push_back(vec_t'{4'b0001, 8'h55, 8'h33, 16'h0022, 1'b0});
    vecs.push_back(vec_t'{4'b0010, 8'h55, 8'h33, 16'h10EF, 1'b0});
    vecs.push_back(vec_t'{4'b0011, 8'h55, 8'h33, 16'h0001, 1'b0});
    vecs.push_back(vec_t'{4'b0100, 8'h55, 8'h33, 16'h0011, 1'b0});
    vecs.push_back(vec_t'{4'b0101, 8'h55, 8'h33, 16'h0077, 1'b0});
    vecs.push_back(vec_t'{4'b0110, 8'h55, 8'h33, 16'h00EE, 1'b0});
    vecs.push_back(vec_t'{4'b0111, 8'h55, 8'h33, 16'h0088, 1'b0});
    vecs.push_back(vec_t'{4'b1000, 8'h55, 8'h33, 16'h0000, 1'b0});
    vecs.push_back(vec_t'{4'b1001, 8'h55, 8'h33, 16'h0000, 1'b0});
    vecs.push_back(vec_t'{4'b1010, 8'h55, 8'h33, 16'h0002, 1'b0});
    vecs.push_back(vec_t'{4'b1011, 8'h55, 8'h33, 16'h0000, 1'b0});
    vecs.push_back(vec_t'{4'b1001, 8'h40, 8'h40, 16'h0001, 1'b0});
    vecs.push_back(vec_t'{4'b1011, 8'h10, 8'h20, 16'h0003, 1'b0});
    vecs.push_back(vec_t'{4'b1010, 8'h10, 8'h20, 16'h0000, 1'b0});
    vecs.push_back(vec_t'{4'b1100, 8'h55, 8'h33, 16'h002A, 1'b0});
    vecs.push_back(vec_t'{4'b1101, 8'h55, 8'h33, 16'h00AA, 1'b0});
    vecs.push_back(vec_t'{4'b1110, 8'h55, 8'h33, 16'h0019, 1'b0});
    vecs.push_back(vec_t'{4'b1111, 8'h55, 8'h33, 16'h0066, 1'b0});
    vecs.push_back(vec_t'{4'b1101, 8'hFF, 8'h33, 16'h01FE, 1'b0});
    vecs.push_back(vec_t'{4'b1111, 8'h12, 8'h80, 16'h0100, 1'b0});
    // Arithmetic edge cases
    vecs.push_back(vec_t'{4'b0000, 8'hFF, 8'h01, 16'h0100, 1'b1});
    vecs.push_back(vec_t'{4'b0001, 8'h01, 8'h02, 16'hFFFF, 1'b1});
    vecs.push_back(vec_t'{4'b0011, 8'h55, 8'h00, 16'h0000, 1'b0});
    vecs.push_back(vec_t'{4'b0011, 8'hFF, 8'h10, 16'h000F, 1'b0});
    vecs.push_back(vec_t'{4'b0010, 8'hFF, 8'hFF, 16'hFE01, 1'b0});
    vecs.push_back(vec_t'{4'b0001, 8'h33, 8'h33, 16'h0000, 1'b0});

    // Reset held for several edges with an arithmetic opcode.
    RST = 1'b1; A = 8'h55; B = 8'h33; ALU_FUN = 4'b0000;
    repeat (3) @(posedge CLK);
    #1;
    check_regs("reset", -1, 16'h0, 1'b0);
    check("reset enables",
          32'({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}), 32'h8);

    @(negedge CLK);
    RST = 1'b0;

    foreach (vecs[i]) begin
      @(negedge CLK);
      A = vecs[i].a; B = vecs[i].b; ALU_FUN = vecs[i].fun;
      #1;
      check($sformatf("v%0d enables", i),
            32'({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}),
            32'(4'b1000 >> vecs[i].fun[3:2]));
      @(posedge CLK);
      #1;
      check_regs($sformatf("v%0d op%b", i, vecs[i].fun),
                 int'(vecs[i].fun[3:2]), vecs[i].val, vecs[i].carry);
    end

    // Mid-sweep reset: results clear on the reset edge, enables unaffected,
    // and the first edge after release carries a valid result again.
    @(negedge CLK);
    A = 8'h55; B = 8'h33; ALU_FUN = 4'b0000;
    @(posedge CLK); #1;
    check_regs("pre-reset add", 0, 16'h0088, 1'b0);
    @(negedge CLK);
    RST = 1'b1; ALU_FUN = 4'b0010;
    #1;
    check("mid reset arith_enable", 32'(Arith_Enable), 32'd1);
    @(posedge CLK); #1;
    check_regs("mid reset", -1, 16'h0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check_regs("post reset mul", 0, 16'h10EF, 1'b0);

    // Reset over a shift opcode, then a direct shift->logic switch.
    @(negedge CLK);
    RST = 1'b1; ALU_FUN = 4'b1101;
    @(posedge CLK); #1;
    check_regs("reset over shift", -1, 16'h0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check_regs("shift after reset", 3, 16'h00AA, 1'b0);
    @(negedge CLK);
    ALU_FUN = 4'b0100;
    @(posedge CLK); #1;
    check_regs("shift to and", 1, 16'h0011, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_top.md
# alu_top

Registered 8-bit ALU built from four function units (arithmetic, logic, compare, shift) selected by a 4-bit opcode. A combinational decoder on `ALU_FUN[3:2]` enables exactly one unit. Each unit owns its own registered result bus and valid flag. The block is a leaf datapath element: operands and opcode come from the surrounding controller, and each unit's result is consumed together with its flag.

## Interface
- `IN_WIDTH`, default 8: operand width.
- `OUT_WIDTH`, default 16: arithmetic, logic and shift result width.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `A` in 8: operand A, unsigned.
- `B` in 8: operand B, unsigned.
- `ALU_FUN` in 4: opcode.
- `Arith_Enable`, `Logic_Enable`, `CMP_Enable`, `Shift_Enable` out 1 each: combinational one-hot decode of `ALU_FUN[3:2]` (00, 01, 10, 11 respectively).
- `Arith_OUT` out 16, `Carry_OUT` out 1, `Arith_Flag` out 1: arithmetic result, carry/borrow, valid.
- `Logic_OUT` out 16, `Logic_Flag` out 1: logic result, valid.
- `CMP_OUT` out 4, `CMP_Flag` out 1: compare code, valid.
- `SHIFT_OUT` out 16, `SHIFT_Flag` out 1: shift result, valid.

## Operation
- Arithmetic (00xx), all results zero-extended to 16 bits:
  - 0000: A+B. `Carry_OUT` = bit 8 of the sum.
  - 0001: A−B, modulo 2^16. `Carry_OUT` = 1 when A<B (borrow).
  - 0010: A×B, full 16-bit product. `Carry_OUT` = 0.
  - 0011: A/B, integer quotient. If B=0, result = 16'h0000. `Carry_OUT` = 0.
- Logic (01xx), computed on 8 bits then zero-extended: 0100 AND, 0101 OR, 0110 NAND, 0111 NOR.
- Compare (10xx), `CMP_OUT` as a code:
  - 1000: NOP, output 0.
  - 1001: 1 if A==B, else 0.
  - 1010: 2 if A>B, else 0.
  - 1011: 3 if A<B, else 0.
- Shift (11xx), logical, zero fill, zero-extended:
  - 1100: A>>1.
  - 1101: A<<1, 9 significant bits, bit 8 kept.
  - 1110: B>>1.
  - 1111: B<<1, 9 significant bits, bit 8 kept.
- Unit enabled: its result register loads the new value and its flag register loads 1.
- Unit not enabled: its result register loads 0, its flag loads 0, and `Carry_OUT` loads 0 for the arithmetic unit.
- Consequence: at most one flag is high in any cycle.

## Timing
- Enables are purely combinational from `ALU_FUN` and are unaffected by `RST`.
- All result, carry and flag outputs are registered, with 1-cycle latency. Inputs present before rising edge N appear after edge N.
- While `RST`=1 at a rising edge: every registered output becomes 0. Reset wins over any opcode.
- Reset asserted mid-operation clears results on that edge. The first valid result appears on the first edge with `RST`=0.
- Opcode change: on the next edge the old unit's outputs clear and the new unit's outputs load, in the same cycle.
- Operands may change every cycle; there is no handshake.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (`ALU_ADD` … `ALU_SHL_B`);
  - unit-select encodings (`SEL_ARITH` = 2'b00, `SEL_LOGIC` = 2'b01, `SEL_CMP` = 2'b10, `SEL_SHIFT` = 2'b11);
  - compare codes (`CMP_EQ` = 1, `CMP_GT` = 2, `CMP_LT` = 3).
- Sub-modules:
  - `alu_decoder`: combinational enable generation.
  - `arith_unit`, `logic_unit`, `cmp_unit`, `shift_unit`: each registered, each taking `CLK`, `RST`, its enable and `ALU_FUN[1:0]`.
- `alu_top` only instantiates and wires these.

## Test plan
- `RST`=1 for several edges with `ALU_FUN`=0000 → all registered outputs 0. `Arith_Enable`=1.
- A=0x55, B=0x33, release reset, sweep 0000–0011, one opcode per several cycles → `Arith_OUT`:
  - 0000: 0x0088, carry 0.
  - 0001: 0x0022, carry 0.
  - 0010: 0x10EF.
  - 0011: 0x0001.
  - `Arith_Flag`=1 throughout; all other flags 0.
- Same operands, 0100–0111 → `Logic_OUT` = 0x0011, 0x0077, 0x00EE, 0x0088. `Logic_Flag`=1 and `Arith_OUT` cleared to 0 one edge after the switch.
- Same operands, 1000–1011 → `CMP_OUT` = 0, 0, 2, 0. Then A=B=0x40 with 1001 → 1, and A=0x10, B=0x20 with 1011 → 3.
- Same operands, 1100–1111 → `SHIFT_OUT` = 0x002A, 0x00AA, 0x0019, 0x0066. Then A=0xFF with 1101 → 0x01FE.
- Edge cases:
  - A=0xFF, B=0x01, 0000 → 0x0100, carry 1.
  - 0001 with A=0x01, B=0x02 → 0xFFFF, carry 1.
  - 0011 with B=0 → 0x0000.
  - `RST`=1 mid-sweep → outputs 0 on that edge.
